carfield_mailbox_responder: RTL and testbench
=============================================

// Module: carfield_mailbox_responder
//
// PURPOSE
// - Register-interface responder for the mailbox window (0x4000_0000, 4 KiB) on the external AXI slave map, reached via an AXI-to-reg bridge.
// - Holds NumMbox mailboxes for host, safety island and integer cluster. Each has 2 letter words, sender and receiver doorbells, and enables.
// - Drives one level-sensitive interrupt pair per mailbox.
//
// PARAMETERS
// - NumMbox    8   number of mailboxes, 1..64; stride 0x40 fits 4 KiB.
// - AddrWidth  12  request address width (byte address inside the window).
// - DataWidth  32  register width; only 32 is supported.
//
// PORTS
// clk_i         in   1          clock
// rst_ni        in   1          asynchronous reset, active-low
// req_valid_i   in   1          request valid; held until rsp_ready_o
// req_write_i   in   1          1 = write, 0 = read
// req_addr_i    in   AddrWidth  byte address; bits [1:0] ignored
// req_wdata_i   in   DataWidth  write data
// req_wstrb_i   in   4          byte strobes
// rsp_ready_o   out  1          response strobe; one cycle per transaction
// rsp_rdata_o   out  DataWidth  read data, valid with rsp_ready_o
// rsp_error_o   out  1          decode error, valid with rsp_ready_o
// snd_irq_o     out  NumMbox    per-mailbox sender interrupt (SND_STAT & SND_EN)
// rcv_irq_o     out  NumMbox    per-mailbox receiver interrupt (RCV_STAT & RCV_EN)
//
// BEHAVIOUR
// - Decode: mbox = addr[11:6]; off = addr[5:0].
// - Register map per mailbox (offset, access):
//   - 0x00 LETTER0 RW
//   - 0x04 LETTER1 RW
//   - 0x08 SND_STAT RO
//   - 0x0C SND_SET W1S
//   - 0x10 SND_CLR W1C
//   - 0x14 SND_EN RW
//   - 0x20 RCV_STAT RO
//   - 0x24 RCV_SET W1S
//   - 0x28 RCV_CLR W1C
//   - 0x2C RCV_EN RW
// - STAT and EN registers are 1 bit (bit 0). Their other bits read 0. SET and CLR read 0.
// - Strobes:
//   - LETTER writes honour req_wstrb_i per byte.
//   - 1-bit registers update only if req_wstrb_i[0]=1.
// - Error: mbox >= NumMbox or an unmapped offset -> rsp_error_o=1, rdata=0, no state change.
// - Writes to RO registers -> error=0, ignored.
// - FSM, 2 states:
//   - IDLE: on req_valid_i, execute the access at this clock edge (write commits, read data registered) -> RESP.
//   - RESP: rsp_ready_o=1 for exactly one cycle, with rdata and error -> IDLE.
// - Latency: response 1 cycle after the accepting edge. Minimum 2 cycles per transaction; back-to-back accepted from IDLE.
// - A read of a register written in the previous transaction returns the new value.
// - Interrupts: combinational from registered STAT & EN. They change in the cycle after the committing edge.
// - SET on an already-set STAT and CLR on an already-clear STAT are no-ops.
// - Reset (async, any state, including mid-transaction):
//   - FSM -> IDLE; a request in flight is dropped and must be reissued.
//   - All letters, STAT and EN -> 0.
//   - rsp_ready_o=0, rsp_rdata_o=0, rsp_error_o=0, snd_irq_o=0, rcv_irq_o=0.
//
// STRUCTURE
// - carfield_pkg gains:
//   - MailboxStride = 'h40.
//   - typedef enum mbox_reg_off_t for the ten offsets.
//   - MailboxNumDefault = 8; the package's MailboxSize ('h1000) bounds NumMbox.
// - Sub-module carfield_mailbox_slot: one mailbox's registers plus its irq pair, instantiated NumMbox times.
//   - Inputs: decoded write-enable, offset, wdata, wstrb.
//   - Output: read mux.
// - Top level holds the FSM, the address decode and the response registers.
//
// TESTING
// - Reset: assert rst_ni=0 mid-RESP.
//   -> rsp_ready_o=0, all irqs 0, then all registers read 0 (checks reset state).
// - Letters: write LETTER0 of mbox 3 (addr 0x0C0) = 0xDEADBEEF with strb 0xF, then write 0x00000011 with strb 0x1.
//   -> read returns 0xDEADBE11; rsp_ready_o arrives exactly 1 cycle after acceptance.
// - Doorbell and enable, mbox 5:
//   - write RCV_EN=1 (0x16C) -> rcv_irq_o[5] stays 0.
//   - write RCV_SET=1 (0x164) -> rcv_irq_o[5]=1 the cycle after the edge; RCV_STAT (0x160) reads 1.
//   - write RCV_CLR=1 (0x168) -> irq 0.
//   - write RCV_EN=0 while STAT=1 -> irq masks to 0 and STAT is unchanged.
// - Decode error: read 0x200 with NumMbox=8 (mbox 8) -> rsp_error_o=1, rdata=0.
//   -> write 0x018 (unmapped offset) -> error=1, no register changes.
// - Back-to-back: 4 consecutive writes with valid held high.
//   -> one ready per transaction, 2-cycle throughput, all values committed in order.
// - Independence: set SND of mbox 0 and RCV of mbox 7.
//   -> only snd_irq_o[0] and rcv_irq_o[7] assert; SET/CLR offsets read 0.

Source files
------------

// File: rtl/carfield_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | carfield_pkg: mailbox window constants and register offset map.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package carfield_pkg;

    localparam int unsigned MailboxSize       = 32'h1000;
    localparam int unsigned MailboxStride     = 32'h40;
    localparam int unsigned MailboxNumDefault = 8;

    typedef enum logic [5:0] {
        MBOX_LETTER0  = 6'h00,
        MBOX_LETTER1  = 6'h04,
        MBOX_SND_STAT = 6'h08,
        MBOX_SND_SET  = 6'h0C,
        MBOX_SND_CLR  = 6'h10,
        MBOX_SND_EN   = 6'h14,
        MBOX_RCV_STAT = 6'h20,
        MBOX_RCV_SET  = 6'h24,
        MBOX_RCV_CLR  = 6'h28,
        MBOX_RCV_EN   = 6'h2C
    } mbox_reg_off_t;

    function automatic logic mbox_off_mapped(input logic [5:0] off);
        case (off)
            MBOX_LETTER0, MBOX_LETTER1, MBOX_SND_STAT, MBOX_SND_SET, MBOX_SND_CLR,
            MBOX_SND_EN, MBOX_RCV_STAT, MBOX_RCV_SET, MBOX_RCV_CLR, MBOX_RCV_EN:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/carfield_mailbox_slot.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | carfield_mailbox_slot: one mailbox (letters, doorbells, enables, irqs).   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module carfield_mailbox_slot
    import carfield_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [5:0]             off_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   snd_irq_o,
    output logic                   rcv_irq_o
);

    logic [DataWidth-1:0] letter0_q, letter0_d;
    logic [DataWidth-1:0] letter1_q, letter1_d;
    logic snd_stat_q, snd_stat_d, snd_en_q, snd_en_d;
    logic rcv_stat_q, rcv_stat_d, rcv_en_q, rcv_en_d;
    logic w_bit0;

    // 1-bit registers only react when byte lane 0 is strobed
    assign w_bit0 = wstrb_i[0] & wdata_i[0];

    always_comb begin
        letter0_d  = letter0_q;
        letter1_d  = letter1_q;
        snd_stat_d = snd_stat_q;
        snd_en_d   = snd_en_q;
        rcv_stat_d = rcv_stat_q;
        rcv_en_d   = rcv_en_q;
        if (we_i) begin
            case (mbox_reg_off_t'(off_i))
                MBOX_LETTER0: begin
                    for (int b = 0; b < DataWidth/8; b++) begin
                        if (wstrb_i[b]) letter0_d[8*b +: 8] = wdata_i[8*b +: 8];
                    end
                end
                MBOX_LETTER1: begin
                    for (int b = 0; b < DataWidth/8; b++) begin
                        if (wstrb_i[b]) letter1_d[8*b +: 8] = wdata_i[8*b +: 8];
                    end
                end
                MBOX_SND_SET: if (w_bit0) snd_stat_d = 1'b1;
                MBOX_SND_CLR: if (w_bit0) snd_stat_d = 1'b0;
                MBOX_SND_EN:  if (wstrb_i[0]) snd_en_d = wdata_i[0];
                MBOX_RCV_SET: if (w_bit0) rcv_stat_d = 1'b1;
                MBOX_RCV_CLR: if (w_bit0) rcv_stat_d = 1'b0;
                MBOX_RCV_EN:  if (wstrb_i[0]) rcv_en_d = wdata_i[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            letter0_q  <= '0;
            letter1_q  <= '0;
            snd_stat_q <= 1'b0;
            snd_en_q   <= 1'b0;
            rcv_stat_q <= 1'b0;
            rcv_en_q   <= 1'b0;
        end else begin
            letter0_q  <= letter0_d;
            letter1_q  <= letter1_d;
            snd_stat_q <= snd_stat_d;
            snd_en_q   <= snd_en_d;
            rcv_stat_q <= rcv_stat_d;
            rcv_en_q   <= rcv_en_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (mbox_reg_off_t'(off_i))
            MBOX_LETTER0:  rdata_o = letter0_q;
            MBOX_LETTER1:  rdata_o = letter1_q;
            MBOX_SND_STAT: rdata_o[0] = snd_stat_q;
            MBOX_SND_EN:   rdata_o[0] = snd_en_q;
            MBOX_RCV_STAT: rdata_o[0] = rcv_stat_q;
            MBOX_RCV_EN:   rdata_o[0] = rcv_en_q;
            default: ;
        endcase
    end

    assign snd_irq_o = snd_stat_q & snd_en_q;
    assign rcv_irq_o = rcv_stat_q & rcv_en_q;

endmodule
`default_nettype wire

// File: rtl/carfield_mailbox_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | carfield_mailbox_responder: register responder for the mailbox window.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module carfield_mailbox_responder
    import carfield_pkg::*;
#(
    parameter int unsigned NumMbox   = MailboxNumDefault,
    parameter int unsigned AddrWidth = 12,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [3:0]           req_wstrb_i,
    output logic                 rsp_ready_o,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic [NumMbox-1:0]   snd_irq_o,
    output logic [NumMbox-1:0]   rcv_irq_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StResp = 1'b1;

    localparam int unsigned MaxMbox    = MailboxSize / MailboxStride;
    localparam logic [6:0]  NumMboxLim = 7'((NumMbox < MaxMbox) ? NumMbox : MaxMbox);

    logic [0:0]           state_q, state_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 error_q, error_d;

    logic [5:0]           w_mbox;
    logic [5:0]           w_off;
    logic                 w_err;
    logic                 w_accept;
    logic [NumMbox-1:0]   w_sel;
    logic [DataWidth-1:0] w_slot_rdata [NumMbox];
    logic [DataWidth-1:0] w_rd_mux;
    logic                 unused_addr_lo;

    assign w_mbox         = req_addr_i[11:6];
    assign w_off          = {req_addr_i[5:2], 2'b00};
    assign unused_addr_lo = ^req_addr_i[1:0];

    if (AddrWidth > 12) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr_i[AddrWidth-1:12];
    end

    assign w_err    = ({1'b0, w_mbox} >= NumMboxLim) || !mbox_off_mapped(w_off);
    assign w_accept = (state_q == StIdle) && req_valid_i;

    for (genvar i = 0; i < NumMbox; i++) begin : g_slot
        assign w_sel[i] = (w_mbox == 6'(i));

        carfield_mailbox_slot #(
            .DataWidth (DataWidth)
        ) u_slot (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .we_i      (w_accept & req_write_i & ~w_err & w_sel[i]),
            .off_i     (w_off),
            .wdata_i   (req_wdata_i),
            .wstrb_i   (req_wstrb_i),
            .rdata_o   (w_slot_rdata[i]),
            .snd_irq_o (snd_irq_o[i]),
            .rcv_irq_o (rcv_irq_o[i])
        );
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NumMbox; i++) begin
            if (w_sel[i]) w_rd_mux = w_slot_rdata[i];
        end
    end

    // Writes and errored accesses answer with zero data
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = StResp;
                    rdata_d = (req_write_i || w_err) ? '0 : w_rd_mux;
                    error_d = w_err;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign rsp_ready_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;

endmodule
`default_nettype wire

// File: tb/tb_carfield_mailbox_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_carfield_mailbox_responder: randomized bench with a register model.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_carfield_mailbox_responder;

    localparam int NUM = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_write = 1'b0;
    logic [11:0]     req_addr = '0;
    logic [31:0]     req_wdata = '0;
    logic [3:0]      req_wstrb = '0;
    logic            rsp_ready;
    logic [31:0]     rsp_rdata;
    logic            rsp_error;
    logic [NUM-1:0]  snd_irq;
    logic [NUM-1:0]  rcv_irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    carfield_mailbox_responder #(
        .NumMbox   (NUM),
        .AddrWidth (12),
        .DataWidth (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .rsp_ready_o (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .snd_irq_o   (snd_irq),
        .rcv_irq_o   (rcv_irq)
    );

    // Behavioural register model
    logic [31:0] m_let [NUM][2];
    bit          m_sst [NUM];
    bit          m_sen [NUM];
    bit          m_rst [NUM];
    bit          m_ren [NUM];
    logic [5:0]  map_offs [10] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h20, 6'h24, 6'h28, 6'h2C};

    function automatic void m_clear();
        for (int i = 0; i < NUM; i++) begin
            m_let[i][0] = '0; m_let[i][1] = '0;
            m_sst[i] = 0; m_sen[i] = 0; m_rst[i] = 0; m_ren[i] = 0;
        end
    endfunction

    function automatic bit m_err(input logic [11:0] a);
        int mb;
        logic [5:0] off;
        bit hit;
        mb = int'(a[11:6]);
        off = {a[5:2], 2'b00};
        hit = 0;
        for (int k = 0; k < 10; k++) if (map_offs[k] == off) hit = 1;
        return (mb >= NUM) || !hit;
    endfunction

    function automatic void m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int mb;
        logic [5:0] off;
        mb = int'(a[11:6]);
        off = {a[5:2], 2'b00};
        if (m_err(a)) return;
        case (off)
            6'h00, 6'h04: for (int b = 0; b < 4; b++) if (s[b]) m_let[mb][off[2]][8*b +: 8] = d[8*b +: 8];
            6'h0C: if (s[0] && d[0]) m_sst[mb] = 1;
            6'h10: if (s[0] && d[0]) m_sst[mb] = 0;
            6'h14: if (s[0]) m_sen[mb] = d[0];
            6'h24: if (s[0] && d[0]) m_rst[mb] = 1;
            6'h28: if (s[0] && d[0]) m_rst[mb] = 0;
            6'h2C: if (s[0]) m_ren[mb] = d[0];
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int mb;
        logic [5:0] off;
        mb = int'(a[11:6]);
        off = {a[5:2], 2'b00};
        if (m_err(a)) return 32'h0;
        case (off)
            6'h00, 6'h04: return m_let[mb][off[2]];
            6'h08: return {31'h0, m_sst[mb]};
            6'h14: return {31'h0, m_sen[mb]};
            6'h20: return {31'h0, m_rst[mb]};
            6'h2C: return {31'h0, m_ren[mb]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [NUM-1:0] m_snd_irq();
        logic [NUM-1:0] v;
        for (int i = 0; i < NUM; i++) v[i] = m_sst[i] & m_sen[i];
        return v;
    endfunction

    function automatic logic [NUM-1:0] m_rcv_irq();
        logic [NUM-1:0] v;
        for (int i = 0; i < NUM; i++) v[i] = m_rst[i] & m_ren[i];
        return v;
    endfunction

    // One transaction from IDLE; returns what was seen one and two cycles after acceptance
    task automatic xact(input bit wr, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic er, output logic rdy1, output logic rdy2,
                        output logic [NUM-1:0] sirq, output logic [NUM-1:0] rirq);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = st;
        @(posedge clk); #1;
        rdy1 = rsp_ready; rd = rsp_rdata; er = rsp_error; sirq = snd_irq; rirq = rcv_irq;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rdy2 = rsp_ready;
        if (wr) m_write(a, wd, st);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er, r1, r2; logic [NUM-1:0] si, ri;
        logic [11:0] a;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({rsp_ready, rsp_error, rsp_rdata, snd_irq, rcv_irq} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got rdy=%b err=%b rdata=%h snd=%b rcv=%b, want all 0",
                              rsp_ready, rsp_error, rsp_rdata, snd_irq, rcv_irq);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        m_clear();
        xact(1, 12'h094, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        xact(1, 12'h08C, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        xact(1, 12'h0AC, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        xact(1, 12'h0A4, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        n_vec++;
        if (si !== m_snd_irq() || ri !== m_rcv_irq()) begin
            n_err++; $display("FAIL pre_reset_irq: got snd=%b rcv=%b, want snd=%b rcv=%b", si, ri, m_snd_irq(), m_rcv_irq());
        end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h0C0; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        @(posedge clk); #1;
        n_vec++;
        if (rsp_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_resp_ready: got %b want 1", rsp_ready);
        end
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        n_vec++;
        if ({rsp_ready, rsp_error, rsp_rdata, snd_irq, rcv_irq} !== '0) begin
            n_err++; $display("FAIL mid_resp_reset: got rdy=%b err=%b rdata=%h snd=%b rcv=%b, want all 0",
                              rsp_ready, rsp_error, rsp_rdata, snd_irq, rcv_irq);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        m_clear();
        for (int mb = 0; mb < NUM; mb++) begin
            for (int k = 0; k < 10; k++) begin
                a = {mb[5:0], map_offs[k]};
                xact(0, a, 32'h0, 4'h0, rd, er, r1, r2, si, ri);
                n_vec++;
                if (rd !== 32'h0 || er !== 1'b0 || r1 !== 1'b1) begin
                    n_err++; $display("FAIL reset_readback @%h: got rdata=%h err=%b rdy=%b, want 0/0/1", a, rd, er, r1);
                end
            end
        end
    endtask

    task automatic test_letters();
        logic [31:0] rd, d; logic er, r1, r2; logic [NUM-1:0] si, ri;
        logic [11:0] a;
        logic [3:0] s;
        xact(1, 12'h0C0, 32'hDEADBEEF, 4'hF, rd, er, r1, r2, si, ri);
        n_vec++;
        if (r1 !== 1'b1 || r2 !== 1'b0) begin
            n_err++; $display("FAIL letter_latency: got rdy(+1)=%b rdy(+2)=%b, want 1 0", r1, r2);
        end
        xact(1, 12'h0C0, 32'h00000011, 4'h1, rd, er, r1, r2, si, ri);
        xact(0, 12'h0C0, 32'h0, 4'h0, rd, er, r1, r2, si, ri);
        n_vec++;
        if (rd !== 32'hDEADBE11 || er !== 1'b0) begin
            n_err++; $display("FAIL letter_strobe: got %h err=%b, want deadbe11 err=0", rd, er);
        end
        for (int n = 0; n < 24; n++) begin
            a = {6'($urandom_range(0, NUM-1)), 3'b000, 1'($urandom_range(0, 1)), 2'b00};
            d = $urandom;
            s = 4'($urandom);
            xact(1, a, d, s, rd, er, r1, r2, si, ri);
            a = {6'($urandom_range(0, NUM-1)), 3'b000, 1'($urandom_range(0, 1)), 2'b00};
            xact(0, a, 32'h0, 4'h0, rd, er, r1, r2, si, ri);
            n_vec++;
            if (rd !== m_read(a) || er !== 1'b0) begin
                n_err++; $display("FAIL letter_random @%h: got %h err=%b, want %h err=0", a, rd, er, m_read(a));
            end
        end
    endtask

    task automatic test_doorbell();
        logic [31:0] rd; logic er, r1, r2; logic [NUM-1:0] si, ri;
        xact(1, 12'h16C, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        n_vec++;
        if (ri[5] !== 1'b0 || ri !== m_rcv_irq()) begin
            n_err++; $display("FAIL db_enable_only: got rcv=%b, want %b", ri, m_rcv_irq());
        end
        xact(1, 12'h164, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        n_vec++;
        if (ri[5] !== 1'b1 || ri !== m_rcv_irq()) begin
            n_err++; $display("FAIL db_set_irq: got rcv=%b, want %b", ri, m_rcv_irq());
        end
        xact(1, 12'h164, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        xact(0, 12'h160, 32'h0, 4'h0, rd, er, r1, r2, si, ri);
        n_vec++;
        if (rd !== 32'h1 || er !== 1'b0) begin
            n_err++; $display("FAIL db_stat_read: got %h err=%b, want 00000001 err=0", rd, er);
        end
        xact(1, 12'h168, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        n_vec++;
        if (ri[5] !== 1'b0 || ri !== m_rcv_irq()) begin
            n_err++; $display("FAIL db_clr_irq: got rcv=%b, want %b", ri, m_rcv_irq());
        end
        xact(1, 12'h168, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        xact(1, 12'h164, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        xact(1, 12'h16C, 32'h0, 4'h1, rd, er, r1, r2, si, ri);
        xact(0, 12'h160, 32'h0, 4'h0, rd, er, r1, r2, si, ri);
        n_vec++;
        if (ri[5] !== 1'b0 || rd !== 32'h1) begin
            n_err++; $display("FAIL db_mask: got rcv[5]=%b stat=%h, want 0 00000001", ri[5], rd);
        end
    endtask

    task automatic test_decode_error();
        logic [31:0] rd; logic er, r1, r2; logic [NUM-1:0] si, ri;
        logic [11:0] a;
        xact(0, 12'h200, 32'h0, 4'h0, rd, er, r1, r2, si, ri);
        n_vec++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_err++; $display("FAIL err_mbox_range: got err=%b rdata=%h, want 1 00000000", er, rd);
        end
        xact(1, 12'h018, 32'hFFFFFFFF, 4'hF, rd, er, r1, r2, si, ri);
        n_vec++;
        if (er !== 1'b1) begin
            n_err++; $display("FAIL err_unmapped_off: got err=%b want 1", er);
        end
        xact(1, 12'h148, 32'h0, 4'hF, rd, er, r1, r2, si, ri);
        n_vec++;
        if (er !== 1'b0) begin
            n_err++; $display("FAIL ro_write_err: got err=%b want 0", er);
        end
        for (int n = 0; n < 16; n++) begin
            a = {6'($urandom_range(0, 15)), 4'($urandom), 2'($urandom)};
            xact(1, a, $urandom, 4'hF, rd, er, r1, r2, si, ri);
            n_vec++;
            if (er !== 1'(m_err(a))) begin
                n_err++; $display("FAIL err_random @%h: got err=%b want %b", a, er, m_err(a));
            end
        end
        for (int mb = 0; mb < NUM; mb++) begin
            for (int k = 0; k < 10; k++) begin
                a = {mb[5:0], map_offs[k]};
                xact(0, a, 32'h0, 4'h0, rd, er, r1, r2, si, ri);
                n_vec++;
                if (rd !== m_read(a) || er !== 1'b0) begin
                    n_err++; $display("FAIL err_no_side_effect @%h: got %h err=%b, want %h err=0", a, rd, er, m_read(a));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, d [4]; logic er, r1, r2; logic [NUM-1:0] si, ri;
        logic [11:0] a [4];
        for (int k = 0; k < 4; k++) begin
            a[k] = {6'(k * 2), 6'h04};
            d[k] = $urandom;
        end
        req_valid = 1'b1; req_write = 1'b1; req_wstrb = 4'hF;
        req_addr = a[0]; req_wdata = d[0];
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            m_write(a[k], d[k], 4'hF);
            n_vec++;
            if (rsp_ready !== 1'b1 || rsp_error !== 1'b0) begin
                n_err++; $display("FAIL b2b_ready_%0d: got rdy=%b err=%b, want 1 0", k, rsp_ready, rsp_error);
            end
            if (k < 3) begin
                req_addr = a[k+1]; req_wdata = d[k+1];
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            n_vec++;
            if (rsp_ready !== 1'b0) begin
                n_err++; $display("FAIL b2b_gap_%0d: got rdy=%b want 0", k, rsp_ready);
            end
        end
        for (int k = 0; k < 4; k++) begin
            xact(0, a[k], 32'h0, 4'h0, rd, er, r1, r2, si, ri);
            n_vec++;
            if (rd !== d[k]) begin
                n_err++; $display("FAIL b2b_commit_%0d: got %h want %h", k, rd, d[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, d; logic er, r1, r2; logic [NUM-1:0] si, ri;
        logic [11:0] a;
        bit wr;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0)
                a = {6'($urandom_range(0, 9)), 4'($urandom), 2'b00};
            else
                a = {6'($urandom_range(0, NUM-1)), map_offs[$urandom_range(0, 9)]};
            wr = 1'($urandom);
            d = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 1));
            xact(wr, a, d, 4'($urandom), rd, er, r1, r2, si, ri);
            n_vec++;
            if (er !== 1'(m_err(a)) || (!wr && rd !== m_read(a)) || si !== m_snd_irq() || ri !== m_rcv_irq()) begin
                n_err++; $display("FAIL random_%0d @%h wr=%b: got rd=%h err=%b snd=%b rcv=%b, want rd=%h err=%b snd=%b rcv=%b",
                                  n, a, wr, rd, er, si, ri, m_read(a), m_err(a), m_snd_irq(), m_rcv_irq());
            end
        end
    endtask

    task automatic test_independence();
        logic [31:0] rd; logic er, r1, r2; logic [NUM-1:0] si, ri;
        logic [11:0] a;
        for (int mb = 0; mb < NUM; mb++) begin
            xact(1, {mb[5:0], 6'h10}, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
            xact(1, {mb[5:0], 6'h28}, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        end
        xact(1, 12'h014, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        xact(1, 12'h00C, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        xact(1, 12'h1EC, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        xact(1, 12'h1E4, 32'h1, 4'h1, rd, er, r1, r2, si, ri);
        n_vec++;
        if (si !== 8'h01 || ri !== 8'h80) begin
            n_err++; $display("FAIL indep_irq: got snd=%b rcv=%b, want 00000001 10000000", si, ri);
        end
        for (int k = 0; k < 4; k++) begin
            a = (k < 2) ? {6'd0, (k == 0) ? 6'h0C : 6'h10} : {6'd7, (k == 2) ? 6'h24 : 6'h28};
            xact(0, a, 32'h0, 4'h0, rd, er, r1, r2, si, ri);
            n_vec++;
            if (rd !== 32'h0 || er !== 1'b0) begin
                n_err++; $display("FAIL setclr_read0 @%h: got %h err=%b, want 0 0", a, rd, er);
            end
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_letters();
        test_doorbell();
        test_decode_error();
        test_back_to_back();
        test_random();
        test_independence();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
